// File: rtl/packet_injector.sv
// Source-side NoC injector: turns a (dst, len) request plus payload words into
// a HEADER/BODY/TAIL flit stream on one router input link with enable/ack backpressure.
package packet_injector_pkg;
    localparam int COORD_W   = 4;
    localparam int PAYLOAD_W = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } addr_t;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2
    } flit_type_t;

    typedef struct packed {
        flit_type_t             ftype;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    typedef struct packed {
        addr_t                                  dst_addr;
        logic [PAYLOAD_W-$bits(addr_t)-1:0]     rsvd;
    } control_hdr_t;
endpackage

module packet_injector
    import packet_injector_pkg::*;
#(
    parameter int X         = 1,
    parameter int Y         = 1,
    parameter int MAX_LEN   = 15,
    parameter int LEN_W     = $clog2(MAX_LEN + 1),
    parameter int PAYLOAD_W = packet_injector_pkg::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  addr_t                req_dst,
    input  logic [LEN_W-1:0]     req_len,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [PAYLOAD_W-1:0] data,
    output flit_t                out_flit,
    output logic                 out_enable,
    input  logic                 out_ack,
    output logic                 pkt_sent,
    output logic                 err_self
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BODY  = 2'd1,
        S_ZTAIL = 2'd2
    } state_t;

    localparam addr_t SELF_ADDR = '{x: COORD_W'(X), y: COORD_W'(Y)};

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    flit_t            r_flit, w_flit_nxt;
    logic             r_enable, w_enable_nxt;
    logic             r_pkt_sent, r_err_self, w_err_nxt;
    logic             w_slot_adv, w_req_fire, w_data_fire, w_self, w_tail_xfer;
    control_hdr_t     w_hdr;

    // The output slot can take a new flit when empty or draining this edge.
    assign w_slot_adv  = !r_enable || out_ack;
    assign req_ready   = (r_state == S_IDLE) && w_slot_adv;
    assign data_ready  = (r_state == S_BODY) && w_slot_adv;
    assign w_req_fire  = req_valid && req_ready;
    assign w_data_fire = data_valid && data_ready;
    assign w_self      = (req_dst == SELF_ADDR);
    assign w_tail_xfer = r_enable && out_ack && (r_flit.ftype == FLIT_TAIL);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_flit_nxt   = r_flit;
        w_enable_nxt = r_enable;
        w_err_nxt    = 1'b0;
        w_hdr        = '0;
        w_hdr.dst_addr = req_dst;

        // Anything not reloaded below leaves a bubble once the slot drains.
        if (w_slot_adv)
            w_enable_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    if (w_self) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_flit_nxt.ftype   = FLIT_HEADER;
                        w_flit_nxt.payload = w_hdr;
                        w_enable_nxt       = 1'b1;
                        w_cnt_nxt          = req_len;
                        w_state_nxt        = (req_len != '0) ? S_BODY : S_ZTAIL;
                    end
                end
            end
            S_BODY: begin
                if (w_data_fire) begin
                    w_flit_nxt.ftype   = (r_cnt == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
                    w_flit_nxt.payload = data;
                    w_enable_nxt       = 1'b1;
                    w_cnt_nxt          = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1))
                        w_state_nxt = S_IDLE;
                end
            end
            S_ZTAIL: begin
                // Zero-length packet: close the wormhole with an empty TAIL.
                if (w_slot_adv) begin
                    w_flit_nxt.ftype   = FLIT_TAIL;
                    w_flit_nxt.payload = '0;
                    w_enable_nxt       = 1'b1;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_flit     <= '0;
            r_enable   <= 1'b0;
            r_pkt_sent <= 1'b0;
            r_err_self <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_flit     <= w_flit_nxt;
            r_enable   <= w_enable_nxt;
            r_pkt_sent <= w_tail_xfer;
            r_err_self <= w_err_nxt;
        end
    end

    assign out_flit   = r_flit;
    assign out_enable = r_enable;
    assign pkt_sent   = r_pkt_sent;
    assign err_self   = r_err_self;

endmodule

// File: doc/packet_injector.md
# packet_injector

Source-side network interface for the 2D mesh NoC. It takes a packet request (destination address and length) plus a stream of payload words and serialises them into a HEADER / BODY / TAIL flit sequence on one node input link, honouring the link's enable/ack backpressure. It sits directly upstream of a router `node` port (`node_port.up` side of a link) and is the only agent that opens and closes wormhole connections from a local core.

## Interface
Parameters:
- X, 1, column coordinate of the attached router; used for self-address check
- Y, 1, row coordinate of the attached router; used for self-address check
- MAX_LEN, 15, maximum data flits per packet
- LEN_W, $clog2(MAX_LEN+1), width of req_len
- PAYLOAD_W, $bits(flit_t.payload), width of one payload word

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req_valid  input  1  packet request present
- req_ready  output  1  request accepted on edge where req_valid && req_ready
- req_dst  input  $bits(addr_t)  destination router address
- req_len  input  LEN_W  number of data flits, 0..MAX_LEN
- data_valid  input  1  payload word present
- data_ready  output  1  payload word consumed on edge where data_valid && data_ready
- data  input  PAYLOAD_W  payload word
- out_flit  output  $bits(flit_t)  flit to router (drives node_port.flit)
- out_enable  output  1  out_flit valid (drives node_port.enable)
- out_ack  input  1  router accepts flit (from node_port.ack)
- pkt_sent  output  1  one-cycle pulse after TAIL transfer
- err_self  output  1  one-cycle pulse: request to own address dropped

## Operation
- Transfer rule: a flit moves on a rising edge where out_enable && out_ack. out_flit/out_enable are registers (output slot); held stable while out_enable && !out_ack.
- slot_adv = !out_enable || out_ack (slot free or emptying this edge).
- States: IDLE, BODY, ZTAIL.
- IDLE: req_ready = slot_adv. On accept:
  - req_dst == (X,Y): load nothing, err_self pulses next cycle, stay IDLE.
  - else: slot <- HEADER flit, payload = control_hdr_t with dst_addr = req_dst, all other fields 0; out_enable <- 1; cnt <- req_len; next = BODY if req_len > 0 else ZTAIL.
- BODY: data_ready = slot_adv. On data handshake: slot <- flit with payload = data, type TAIL if cnt == 1 else BODY; cnt <- cnt-1; on cnt == 1 go IDLE. If slot_adv && !data_valid: out_enable <- 0 (bubble; connection stays open downstream).
- ZTAIL: when slot_adv: slot <- TAIL, payload 0, no data consumed; go IDLE.
- If slot_adv in IDLE with no accepted request, out_enable <- 0.
- data_ready = 0 outside BODY; req_ready = 0 outside IDLE.
- pkt_sent: registered, high the cycle after the edge that transfers a TAIL.
- req_len > MAX_LEN: undefined input, not required to be handled.

## Timing
- Reset (rst = 0, async): state IDLE, cnt 0, out_enable 0, out_flit 0, pkt_sent 0, err_self 0; req_ready 1 after release, data_ready 0.
- Reset mid-packet aborts immediately; out_enable drops without TAIL (routers share the same reset).
- Request accepted at edge T -> HEADER visible with out_enable = 1 in cycle T+1.
- With out_ack = 1 and data_valid = 1 continuously: packet of N >= 1 data flits occupies N+1 consecutive cycles; next HEADER follows TAIL with no gap (req_ready = 1 during TAIL cycle because out_ack = 1).
- req_len = 0: HEADER then TAIL, 2 cycles.
- req_ready, data_ready combinationally depend on out_ack; no combinational path from data/req to out_*.
- Simultaneous TAIL transfer and new request: both occur on same edge.

## Test plan
- Reset: hold rst = 0, toggle clk -> out_enable = 0, out_flit = 0, pkt_sent = 0; after release req_ready = 1, data_ready = 0.
- X=1,Y=1, request dst (2,1), len 3, data 0xA,0xB,0xC, out_ack = 1 -> flits HEADER(dst 2,1), BODY 0xA, BODY 0xB, TAIL 0xC on 4 consecutive cycles; pkt_sent pulses once.
- Same packet, out_ack low 2 cycles while BODY 0xA presented -> out_flit held stable, data_ready = 0, no word lost or duplicated.
- len 2, data_valid gap of 3 cycles between words -> out_enable = 0 for 3 cycles between BODY and TAIL, sequence intact.
- len 0 then immediate second request len 1 -> HEADER, TAIL(0), HEADER, TAIL(data) back-to-back, two pkt_sent pulses.
- Request dst (1,1) -> no flit emitted, err_self pulses 1 cycle, req_ready returns 1; rst asserted mid-BODY -> out_enable 0 at once.
